// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client arbiter sharing one single-port synchronous RAM
module ram_arbiter #(
  parameter int A    = 10,
  parameter int D    = 8,
  parameter int PRIO = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic [D-1:0] din0,
  input  logic [D-1:0] din1,
  output logic         ack0,
  output logic         ack1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [D-1:0] rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  // last: port granted on the most recent busy edge; 1 after reset so port 0 wins first contest
  logic last;
  logic gnt0;
  logic gnt1;
  logic sel_we;

  // Grant selection: a lone request always wins; contention resolved by priority mode
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (PRIO == 1 || last) gnt0 = 1'b1;
      else                   gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Steer the granted client onto the RAM port; idle defaults to port 0 with no write
  always_comb begin
    ram_addr = addr0;
    ram_din  = din0;
    sel_we   = 1'b0;
    if (gnt1) begin
      ram_addr = addr1;
      ram_din  = din1;
      sel_we   = we1;
    end else if (gnt0) begin
      sel_we   = we0;
    end
  end

  assign ack0   = gnt0;
  assign ack1   = gnt1;
  // Writes are suppressed for as long as reset is held low
  assign ram_we = sel_we & reset;
  assign rdata  = ram_dout;

  // Round-robin history: remember which port was served, hold it when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end

  // Read-data valid flags, one cycle after a granted read; writes never flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (1-cycle read latency, write-enable strobe, registered read data) between two clients, e.g. a video scan-out reader and a CPU/sprite engine. Each cycle at most one request is granted: the arbiter steers that client's address, data and write enable onto the RAM port, acknowledges it in the same cycle, and flags the returning read data one cycle later. Arbitration is round-robin or fixed-priority by parameter. It sits directly between the clients and the RAM instance.

## Interface
- A, 10, address width in bits (RAM depth 2^A words)
- D, 8, data width in bits
- PRIO, 0, 0 = round-robin; 1 = fixed priority, port 0 always wins
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- req0 / req1  input  1  port n requests an access this cycle
- we0 / we1  input  1  port n access is a write (1) or read (0)
- addr0 / addr1  input  A  port n word address
- din0 / din1  input  D  port n write data
- ack0 / ack1  output  1  combinational; port n granted this cycle
- rvalid0 / rvalid1  output  1  registered; rdata holds port n read data this cycle
- rdata  output  D  shared read data, equals ram_dout
- ram_addr  output  A  to RAM address
- ram_din  output  D  to RAM write data
- ram_we  output  1  to RAM write enable
- ram_dout  input  D  from RAM registered read data

## Operation
- Grant selection (combinational): neither req -> no grant; one req -> grant it; both -> PRIO=1 grants port 0, PRIO=0 grants the port not equal to `last`.
- `last` (1 bit): on every edge with a grant, `last` <= granted port; unchanged when idle. Reset value 1, so port 0 wins the first contested cycle.
- ackN = 1 exactly when port N is granted; a requester keeping req high after ack issues a new, independent access.
- RAM mux: granted port's addrN/dinN/weN drive ram_addr/ram_din/ram_we. No grant -> ram_we=0, ram_addr=addr0, ram_din=din0. ram_we is forced 0 while reset is low.
- rvalidN <= (granted port is N) & ~weN; cleared on the next edge unless reissued. Writes never produce rvalid.
- rdata = ram_dout unconditionally; meaningful only when rvalid0 or rvalid1 is high. At most one rvalid is ever high.
- Write-then-read of the same address by either port on consecutive grants returns the new data (RAM write completes at the grant edge).
- Read and write on the same cycle are impossible (single grant); the losing port simply sees ack low and holds its request.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): last=1, rvalid0=rvalid1=0, ram_we=0; ack outputs follow req inputs combinationally but no RAM write occurs and no rvalid is produced while reset is low. Reset mid-read drops the pending rvalid.
- Grant/ack latency: 0 cycles (same cycle as req).
- Read latency: rvalidN and data at cycle T+1 for a read granted at cycle T.
- Throughput: one access per cycle total; under PRIO=0 with both ports requesting continuously, grants strictly alternate (50/50). Under PRIO=1 port 1 can starve indefinitely (by design).
- No combinational path from ram_dout to any output except rdata.

## Test plan
- Reset: hold reset low 3 cycles with req0=req1=1, we0=1 -> ram_we=0, rvalid0=rvalid1=0; after release first contested cycle grants port 0 (ack0=1, ack1=0).
- Single-port write/read: port 0 writes 0xA5 to addr 0x3FF, next cycle reads 0x3FF -> ack0 both cycles, rvalid0=1 with rdata=0xA5 one cycle after the read, rvalid1 stays 0.
- Round-robin contention (PRIO=0): both ports read continuously for 8 cycles -> acks alternate 0,1,0,1...; rvalid alternates one cycle behind; each port gets exactly 4 grants.
- Fixed priority (PRIO=1): both request for 5 cycles -> ack0=1, ack1=0 every cycle; drop req0 -> ack1=1 the same cycle.
- Write isolation: port 1 writes 0x3C to addr 5 while port 0 read of addr 5 is pending -> port 0 ack only after port 1 (or before per `last`), and its rdata reflects the RAM contents at its own grant edge (0x3C if granted after the write).
- Reset mid-read: grant port 1 read, assert reset before next edge -> rvalid1 stays 0; after release `last`=1 behaviour restored.
